mips_harvard_avalon_bridge: RTL and testbench

Sits directly downstream of the Harvard MIPS CPU and joins its two combinational memory ports (instruction and data) onto one Avalon-MM master with waitrequest. Each CPU cycle runs as a short sequence: fetch the instruction word, then do at most one data access, then pulse cpu_clock_enable for one clk so the CPU commits state. Read data is buffered and presented stably to the CPU for the whole sequence.

---
 rtl/mips_bus_pkg.sv | 14 +
 rtl/bus_wait_timer.sv | 28 ++
 rtl/mips_harvard_avalon_bridge.sv | 131 +++++++++++++
 tb/tb_mips_harvard_avalon_bridge.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the Harvard MIPS to Avalon-MM bridge.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DATA   = 2'd1,
      S_COMMIT = 2'd2,
      S_HALT   = 2'd3
   } t_bridge_state;

   localparam logic [3:0]  BYTEEN_FULL  = 4'b1111;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive stalled bus cycles and flags expiry on the TIMEOUT-th one.
module bus_wait_timer #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   assign expired = stall && (count == CW'(TIMEOUT - 1));

   // Count stalled cycles; any cycle without a stall ends the transfer and clears the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (!stall || expired) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/mips_harvard_avalon_bridge.sv
// Serialises the CPU instruction and data ports onto one Avalon-MM master:
// fetch, optional data access, then a one-clk commit pulse to the CPU.
module mips_harvard_avalon_bridge
   import mips_bus_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_active,
   input  logic [ADDR_W-1:0] cpu_instr_address,
   output logic [31:0]       cpu_instr_readdata,
   input  logic [ADDR_W-1:0] cpu_data_address,
   input  logic              cpu_data_read,
   input  logic              cpu_data_write,
   input  logic [31:0]       cpu_data_writedata,
   output logic [31:0]       cpu_data_readdata,
   output logic              cpu_clock_enable,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   output logic              bus_error
);

   t_bridge_state state;
   t_bridge_state next_state;

   logic data_single;
   logic xfer_active;
   logic xfer_stall;
   logic xfer_done;
   logic timeout;
   logic latch_instr;
   logic latch_data;
   logic set_error;

   // Exactly one of read/write requested is a legal data access.
   assign data_single = cpu_data_read ^ cpu_data_write;
   assign xfer_active = !reset && ((state == S_FETCH) || ((state == S_DATA) && data_single));
   assign xfer_stall  = xfer_active && avm_waitrequest;
   assign xfer_done   = xfer_active && !avm_waitrequest;

   assign avm_byteenable = BYTEEN_FULL;
   assign avm_writedata  = cpu_data_writedata;

   bus_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .stall  (xfer_stall),
      .expired(timeout)
   );

   // Bus strobes, address mux, buffer latch enables and next-state decode.
   always_comb begin
      next_state       = state;
      avm_read         = 1'b0;
      avm_write        = 1'b0;
      avm_address      = {cpu_instr_address[ADDR_W-1:2], 2'b00};
      cpu_clock_enable = 1'b0;
      latch_instr      = 1'b0;
      latch_data       = 1'b0;
      set_error        = 1'b0;
      case (state)
         S_FETCH: begin
            avm_read = xfer_active;
            if (xfer_done) begin
               latch_instr = 1'b1;
               next_state  = S_DATA;
            end else if (timeout) begin
               set_error  = 1'b1;
               next_state = S_DATA;
            end
         end
         S_DATA: begin
            avm_address = {cpu_data_address[ADDR_W-1:2], 2'b00};
            if (cpu_data_read && cpu_data_write) begin
               set_error  = 1'b1;
               next_state = S_COMMIT;
            end else if (data_single) begin
               avm_read  = xfer_active && cpu_data_read;
               avm_write = xfer_active && cpu_data_write;
               if (xfer_done) begin
                  latch_data = cpu_data_read;
                  next_state = S_COMMIT;
               end else if (timeout) begin
                  set_error  = 1'b1;
                  next_state = S_COMMIT;
               end
            end else begin
               next_state = S_COMMIT;
            end
         end
         S_COMMIT: begin
            cpu_clock_enable = !reset;
            next_state       = cpu_active ? S_FETCH : S_HALT;
         end
         default: begin
            next_state = S_HALT;
         end
      endcase
   end

   // State register, read buffers and the sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= S_FETCH;
         cpu_instr_readdata <= '0;
         cpu_data_readdata  <= '0;
         bus_error          <= 1'b0;
      end else begin
         state <= next_state;
         if (latch_instr) begin
            cpu_instr_readdata <= avm_readdata;
         end
         if (latch_data) begin
            cpu_data_readdata <= avm_readdata;
         end
         if (set_error) begin
            bus_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mips_harvard_avalon_bridge.sv
// Table-driven bench for the bridge plus hand-written reset and timeout sequences.
module tb_mips_harvard_avalon_bridge;
   import mips_bus_pkg::*;

   localparam int TB_TIMEOUT = 8;

   logic        clk;
   logic        reset;
   logic        cpu_active;
   logic [31:0] cpu_instr_address;
   logic [31:0] cpu_instr_readdata;
   logic [31:0] cpu_data_address;
   logic        cpu_data_read;
   logic        cpu_data_write;
   logic [31:0] cpu_data_writedata;
   logic [31:0] cpu_data_readdata;
   logic        cpu_clock_enable;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        bus_error;

   int checks_total;
   int checks_passed;

   typedef struct {
      logic        wait_req;
      logic [31:0] rdata;
      logic        active;
      logic        dr;
      logic        dw;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic [31:0] wdata;
      logic        exp_read;
      logic        exp_write;
      logic [31:0] exp_addr;
      logic        exp_ce;
      logic [31:0] exp_instr;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[16];

   mips_harvard_avalon_bridge #(
      .TIMEOUT(TB_TIMEOUT),
      .ADDR_W (32)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .cpu_active        (cpu_active),
      .cpu_instr_address (cpu_instr_address),
      .cpu_instr_readdata(cpu_instr_readdata),
      .cpu_data_address  (cpu_data_address),
      .cpu_data_read     (cpu_data_read),
      .cpu_data_write    (cpu_data_write),
      .cpu_data_writedata(cpu_data_writedata),
      .cpu_data_readdata (cpu_data_readdata),
      .cpu_clock_enable  (cpu_clock_enable),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .bus_error         (bus_error)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      avm_waitrequest    = v.wait_req;
      avm_readdata       = v.rdata;
      cpu_active         = v.active;
      cpu_data_read      = v.dr;
      cpu_data_write     = v.dw;
      cpu_instr_address  = v.iaddr;
      cpu_data_address   = v.daddr;
      cpu_data_writedata = v.wdata;
   endtask

   task automatic check_vector(input int idx, input vec_t v);
      check_output($sformatf("row%0d avm_read", idx), {31'd0, avm_read}, {31'd0, v.exp_read});
      check_output($sformatf("row%0d avm_write", idx), {31'd0, avm_write}, {31'd0, v.exp_write});
      check_output($sformatf("row%0d avm_address", idx), avm_address, v.exp_addr);
      check_output($sformatf("row%0d clock_enable", idx), {31'd0, cpu_clock_enable}, {31'd0, v.exp_ce});
      check_output($sformatf("row%0d instr_readdata", idx), cpu_instr_readdata, v.exp_instr);
      check_output($sformatf("row%0d data_readdata", idx), cpu_data_readdata, v.exp_data);
      check_output($sformatf("row%0d bus_error", idx), {31'd0, bus_error}, {31'd0, v.exp_err});
      if (v.exp_write) begin
         check_output($sformatf("row%0d writedata", idx), avm_writedata, v.wdata);
         check_output($sformatf("row%0d byteenable", idx), {28'd0, avm_byteenable}, 32'h0000_000F);
      end
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;

      //          wait rdata          act dr dw iaddr          daddr          wdata          rd wr addr           ce instr          data           err
      vecs[0]  = '{1'b0, 32'h2402_0005, 1, 0, 0, RESET_VECTOR,   32'h0,         32'h0,         1, 0, 32'hBFC0_0000, 0, 32'h0,         32'h0,         0};
      vecs[1]  = '{1'b0, 32'h0,         1, 0, 0, RESET_VECTOR,   32'h0,         32'h0,         0, 0, 32'h0,         0, 32'h2402_0005, 32'h0,         0};
      vecs[2]  = '{1'b0, 32'h0,         1, 0, 0, RESET_VECTOR,   32'h0,         32'h0,         0, 0, 32'hBFC0_0000, 1, 32'h2402_0005, 32'h0,         0};
      vecs[3]  = '{1'b0, 32'h8C82_0000, 1, 0, 0, 32'hBFC0_0004, 32'h0,         32'h0,         1, 0, 32'hBFC0_0004, 0, 32'h2402_0005, 32'h0,         0};
      vecs[4]  = '{1'b1, 32'h1111_1111, 1, 1, 0, 32'hBFC0_0004, 32'h0000_1006, 32'h0,         1, 0, 32'h0000_1004, 0, 32'h8C82_0000, 32'h0,         0};
      vecs[5]  = '{1'b1, 32'h2222_2222, 1, 1, 0, 32'hBFC0_0004, 32'h0000_1006, 32'h0,         1, 0, 32'h0000_1004, 0, 32'h8C82_0000, 32'h0,         0};
      vecs[6]  = '{1'b0, 32'hDEAD_BEEF, 1, 1, 0, 32'hBFC0_0004, 32'h0000_1006, 32'h0,         1, 0, 32'h0000_1004, 0, 32'h8C82_0000, 32'h0,         0};
      vecs[7]  = '{1'b0, 32'h0,         1, 1, 0, 32'hBFC0_0004, 32'h0000_1006, 32'h0,         0, 0, 32'hBFC0_0004, 1, 32'h8C82_0000, 32'hDEAD_BEEF, 0};
      vecs[8]  = '{1'b0, 32'hAC45_0020, 1, 0, 0, 32'hBFC0_0008, 32'h0,         32'h0,         1, 0, 32'hBFC0_0008, 0, 32'h8C82_0000, 32'hDEAD_BEEF, 0};
      vecs[9]  = '{1'b0, 32'h0,         1, 0, 1, 32'hBFC0_0008, 32'h0000_0020, 32'h1234_5678, 0, 1, 32'h0000_0020, 0, 32'hAC45_0020, 32'hDEAD_BEEF, 0};
      vecs[10] = '{1'b0, 32'h0,         1, 0, 0, 32'hBFC0_0008, 32'h0,         32'h0,         0, 0, 32'hBFC0_0008, 1, 32'hAC45_0020, 32'hDEAD_BEEF, 0};
      vecs[11] = '{1'b0, 32'h0000_0000, 1, 0, 0, 32'hBFC0_000C, 32'h0,         32'h0,         1, 0, 32'hBFC0_000C, 0, 32'hAC45_0020, 32'hDEAD_BEEF, 0};
      vecs[12] = '{1'b0, 32'h5555_5555, 1, 1, 1, 32'hBFC0_000C, 32'h0000_0040, 32'h0,         0, 0, 32'h0000_0040, 0, 32'h0000_0000, 32'hDEAD_BEEF, 0};
      vecs[13] = '{1'b0, 32'h0,         0, 0, 0, 32'hBFC0_000C, 32'h0,         32'h0,         0, 0, 32'hBFC0_000C, 1, 32'h0000_0000, 32'hDEAD_BEEF, 1};
      vecs[14] = '{1'b0, 32'h0,         0, 1, 0, 32'hBFC0_0010, 32'h0,         32'h0,         0, 0, 32'hBFC0_0010, 0, 32'h0000_0000, 32'hDEAD_BEEF, 1};
      vecs[15] = '{1'b0, 32'h0,         1, 1, 0, 32'hBFC0_0010, 32'h0,         32'h0,         0, 0, 32'hBFC0_0010, 0, 32'h0000_0000, 32'hDEAD_BEEF, 1};

      reset = 1'b1;
      apply_stimulus(vecs[0]);
      repeat (2) @(negedge clk);
      #1;
      check_output("reset avm_read", {31'd0, avm_read}, 32'd0);
      check_output("reset avm_write", {31'd0, avm_write}, 32'd0);
      check_output("reset clock_enable", {31'd0, cpu_clock_enable}, 32'd0);
      check_output("reset instr_readdata", cpu_instr_readdata, 32'd0);
      check_output("reset data_readdata", cpu_data_readdata, 32'd0);
      check_output("reset bus_error", {31'd0, bus_error}, 32'd0);

      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i]);
         #1;
         check_vector(i, vecs[i]);
         @(negedge clk);
      end

      // Reset asserted while a data read is stalled.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus('{1'b0, 32'h2402_0005, 1, 0, 0, RESET_VECTOR, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0});
      #1;
      check_output("rst-mid fetch read", {31'd0, avm_read}, 32'd1);
      @(negedge clk);
      apply_stimulus('{1'b1, 32'h0, 1, 1, 0, RESET_VECTOR, 32'h0000_0040, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0});
      #1;
      check_output("rst-mid data read", {31'd0, avm_read}, 32'd1);
      check_output("rst-mid data addr", avm_address, 32'h0000_0040);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_output("rst-mid read low", {31'd0, avm_read}, 32'd0);
      check_output("rst-mid write low", {31'd0, avm_write}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("rst-mid back to fetch", {31'd0, avm_read}, 32'd1);
      check_output("rst-mid fetch addr", avm_address, RESET_VECTOR);
      check_output("rst-mid bus_error", {31'd0, bus_error}, 32'd0);
      check_output("rst-mid instr cleared", cpu_instr_readdata, 32'd0);

      // Permanent stall on the fetch: timeout after TB_TIMEOUT stalled cycles.
      apply_stimulus('{1'b1, 32'hFFFF_FFFF, 1, 0, 0, RESET_VECTOR, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0});
      for (int i = 0; i < TB_TIMEOUT; i++) begin
         #1;
         check_output($sformatf("timeout stall%0d bus_error", i), {31'd0, bus_error}, 32'd0);
         check_output($sformatf("timeout stall%0d read", i), {31'd0, avm_read}, 32'd1);
         @(negedge clk);
      end
      #1;
      check_output("timeout bus_error set", {31'd0, bus_error}, 32'd1);
      check_output("timeout data no read", {31'd0, avm_read}, 32'd0);
      check_output("timeout instr unchanged", cpu_instr_readdata, 32'd0);
      check_output("timeout no commit yet", {31'd0, cpu_clock_enable}, 32'd0);
      @(negedge clk);
      #1;
      check_output("timeout commit pulse", {31'd0, cpu_clock_enable}, 32'd1);
      @(negedge clk);
      #1;
      check_output("timeout refetch", {31'd0, avm_read}, 32'd1);
      check_output("timeout sticky", {31'd0, bus_error}, 32'd1);
      check_output("timeout pulse ended", {31'd0, cpu_clock_enable}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check_output("timeout cleared by reset", {31'd0, bus_error}, 32'd0);
      reset = 1'b0;

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
